// File: rtl/rr_mux_arbiter_pkg.sv
// Shared types and default sizes for the round-robin packet mux arbiter.
package rr_mux_arbiter_pkg;

    localparam int DEFAULT_N_REQ = 4;
    localparam int DEFAULT_W     = 8;

    // IDLE: free to pick a new winner; LOCKED: a multi-beat packet owns the mux
    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_mux_arbiter_pick.sv
// Rotating-priority encoder: finds the first set request starting at ptr,
// wrapping around from N_REQ-1 back to 0.
module rr_pick
    import rr_mux_arbiter_pkg::*;
#(
    parameter int N_REQ = DEFAULT_N_REQ,
    parameter int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic             found,
    output logic [IW-1:0]    index
);

    // Scan from the farthest position back toward ptr so the closest hit wins
    always_comb begin
        found = 1'b0;
        index = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % N_REQ]) begin
                found = 1'b1;
                index = IW'((int'(ptr) + k) % N_REQ);
            end
        end
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin packet arbiter feeding a single registered output slot.
// A packet that starts with in_last = 0 locks the mux to its requester
// until that requester presents its last beat.
module rr_mux_arbiter
    import rr_mux_arbiter_pkg::*;
#(
    parameter int N_REQ = DEFAULT_N_REQ,
    parameter int W     = DEFAULT_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            in_valid,
    input  logic [N_REQ-1:0]            in_last,
    input  logic [N_REQ-1:0][W-1:0]     in_data,
    output logic [N_REQ-1:0]            in_ready,
    output logic                        out_valid,
    output logic [W-1:0]                out_data,
    output logic [$clog2(N_REQ)-1:0]    out_id,
    output logic                        out_last,
    input  logic                        out_ready
);

    localparam int IW = $clog2(N_REQ);

    arb_state_t       state;
    logic [IW-1:0]    ptr;
    logic [IW-1:0]    owner;
    logic [IW-1:0]    pick_index;
    logic             pick_found;
    logic [IW-1:0]    sel;
    logic [IW-1:0]    sel_next;
    logic             slot_free;
    logic             grant;
    logic             accept;

    rr_pick #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_pick (
        .req   (in_valid),
        .ptr   (ptr),
        .found (pick_found),
        .index (pick_index)
    );

    // Select the granted requester and raise its ready only when the slot can take a beat
    always_comb begin
        slot_free = !out_valid || out_ready;
        sel       = (state == LOCKED) ? owner : pick_index;
        sel_next  = (sel == IW'(N_REQ - 1)) ? '0 : sel + 1'b1;
        grant     = rst && slot_free && ((state == LOCKED) || pick_found);
        in_ready  = '0;
        if (grant) begin
            in_ready[sel] = 1'b1;
        end
        accept    = grant && in_valid[sel];
    end

    // Arbitration FSM plus the registered output slot
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            ptr       <= '0;
            owner     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
            out_last  <= 1'b0;
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                out_data  <= in_data[sel];
                out_id    <= sel;
                out_last  <= in_last[sel];
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        ptr <= sel_next;
                        if (!in_last[sel]) begin
                            state <= LOCKED;
                            owner <= sel;
                        end
                    end
                end
                LOCKED: begin
                    if (accept && in_last[sel]) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/rr_mux_arbiter.md
RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing the output mux (2..8).
REQ-002 Parameter W, default 8, data width per beat.
REQ-003 Port clk  input  1  single clock, all state on rising edge.
REQ-004 Port rst  input  1  synchronous, active-low reset (0 = reset).
REQ-005 Port in_valid  input  N_REQ  per-requester beat valid.
REQ-006 Port in_last  input  N_REQ  per-requester last beat of packet.
REQ-007 Port in_data  input  N_REQ x W  per-requester beat data, packed array.
REQ-008 Port in_ready  output  N_REQ  per-requester beat accepted this cycle.
REQ-009 Port out_valid  output  1  registered output beat valid.
REQ-010 Port out_data  output  W  registered muxed data.
REQ-011 Port out_id  output  clog2(N_REQ)  index of the source requester.
REQ-012 Port out_last  output  1  registered copy of the source in_last.
REQ-013 Port out_ready  input  1  downstream accepts out beat.

Function
REQ-014 Beat handshake: transfer on in_valid[i] && in_ready[i]; out transfer on out_valid && out_ready.
REQ-015 Output stage is a single register slot; slot_free = !out_valid || out_ready; all in_ready SHALL be 0 when slot_free = 0.
REQ-016 At most one in_ready bit high per cycle; in_ready SHALL NOT depend on in_data.
REQ-017 Latency: accepted input beat appears on out_* exactly 1 cycle later; out_data/out_id/out_last hold stable while out_valid && !out_ready.
REQ-018 FSM states IDLE and LOCKED; register owner (clog2(N_REQ) bits) and rotating pointer ptr.
REQ-019 IDLE: winner = first i with in_valid[i] searching ptr, ptr+1, ... mod N_REQ; in_ready[winner] = slot_free.
REQ-020 IDLE, winner beat accepted with in_last = 0: go LOCKED, owner <= winner, ptr <= (winner+1) mod N_REQ.
REQ-021 IDLE, winner beat accepted with in_last = 1: stay IDLE, ptr <= (winner+1) mod N_REQ.
REQ-022 LOCKED: in_ready[owner] = slot_free, all other in_ready 0, regardless of other in_valid.
REQ-023 LOCKED, owner beat accepted with in_last = 1: go IDLE; ptr unchanged.
REQ-024 LOCKED, owner in_valid low: no transfer, remain LOCKED indefinitely (no timeout).
REQ-025 No in_valid in IDLE: all in_ready 0, ptr unchanged; out_valid clears when current beat drains.
REQ-026 Simultaneous out drain and new accept in same cycle SHALL give back-to-back out_valid with no bubble.
REQ-027 ptr wraps N_REQ-1 -> 0.

Reset
REQ-028 While rst = 0 at a clock edge: state IDLE, ptr 0, owner 0, out_valid 0, out_data 0, out_id 0, out_last 0.
REQ-029 in_ready SHALL be 0 in every cycle rst = 0.
REQ-030 Reset mid-packet SHALL drop the lock and any held output beat; no partial-packet recovery.

Structure
REQ-031 Package rr_mux_arbiter_pkg holds the state enum (IDLE, LOCKED) and default N_REQ/W constants.
REQ-032 Sub-module rr_pick: combinational rotating-priority encoder (in: req vector, ptr; out: found, index).
REQ-033 Output mux built from in_data indexed by the selected requester; no latches.

Verification
REQ-034 Reset: hold rst = 0 with all in_valid = 1 -> in_ready = 0, out_valid = 0 every cycle; release -> requester 0 accepted first cycle.
REQ-035 Round robin: in_valid = 4'b1111, all in_last = 1, out_ready = 1 -> out_id sequence 0,1,2,3,0 on consecutive cycles, out_valid continuous.
REQ-036 Packet lock: req 1 sends 3 beats (0xA1,0xA2,0xA3, last on 3rd) while req 0 and 2 valid -> out_data A1,A2,A3 with out_id 1, then out_id 2.
REQ-037 Backpressure: out_ready = 0 for 3 cycles with out_data 0x55 -> out_* stable, in_ready = 0; out_ready = 1 -> next beat 1 cycle later.
REQ-038 Owner stall: LOCKED on req 3, in_valid[3] low 4 cycles with req 0 valid -> no in_ready[0], state LOCKED; resume -> packet completes, then req 0.
REQ-039 Mid-packet reset: rst = 0 during LOCKED on req 2 -> out_valid 0 next cycle; after release req 0 wins if valid.
